// File: rtl/iir_pkg.sv
// Shared definitions for the IIR coefficient path: default sizes, coefficient
// addressing, loader states and the passthrough reset bank values.
package iir_pkg;

    localparam int COEFF_WIDTH    = 32;
    localparam int LOG_A0         = 30;
    localparam int LOG_GAIN_UNITY = 18;
    localparam int LOG_DIV        = 2;
    localparam int NUM_COEFF      = 6;

    typedef enum logic [2:0] {
        ADDR_B0   = 3'd0,
        ADDR_B1   = 3'd1,
        ADDR_B2   = 3'd2,
        ADDR_A1   = 3'd3,
        ADDR_A2   = 3'd4,
        ADDR_GAIN = 3'd5
    } coeff_addr_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ARMED
    } ld_state_e;

    function automatic logic [63:0] unity(input int log2);
        return 64'd1 << log2;
    endfunction

    localparam logic [COEFF_WIDTH-1:0] B0_RST   = COEFF_WIDTH'(64'd1 << LOG_A0);
    localparam logic [COEFF_WIDTH-1:0] GAIN_RST = COEFF_WIDTH'(64'd1 << LOG_GAIN_UNITY);

endpackage

// File: rtl/iir_stab_check.sv
// Registered stability-triangle verdict on a1/a2: |a2| < A0 and |a1| < A0 + a2.
// Widened by two bits so |x| of the most negative value and A0 + a2 cannot wrap.
module iir_stab_check #(
    parameter int COEFF_WIDTH = 32,
    parameter int LOG_A0      = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COEFF_WIDTH-1:0] a1_i,
    input  logic [COEFF_WIDTH-1:0] a2_i,
    output logic                   pass_o
);
    localparam int XW = COEFF_WIDTH + 2;

    logic signed [XW-1:0] a1_x, a2_x, a1_abs, a2_abs, unity_x;
    logic                 pass_d, pass_q;

    assign a1_x    = {{2{a1_i[COEFF_WIDTH-1]}}, a1_i};
    assign a2_x    = {{2{a2_i[COEFF_WIDTH-1]}}, a2_i};
    assign unity_x = {{(XW-1){1'b0}}, 1'b1} << LOG_A0;
    assign a1_abs  = a1_x[XW-1] ? -a1_x : a1_x;
    assign a2_abs  = a2_x[XW-1] ? -a2_x : a2_x;
    assign pass_d  = (a2_abs < unity_x) && (a1_abs < (unity_x + a2_x));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pass_q <= 1'b0;
        else     pass_q <= pass_d;
    end

    assign pass_o = pass_q;

endmodule

// File: rtl/iir_coeff_bank_loader.sv
// Shadow/active coefficient bank with atomic commit on the filter frame boundary.
// Define IIR_STAB_CHECK_EN to reject commits whose a1/a2 fail the stability triangle.
module iir_coeff_bank_loader
    import iir_pkg::*;
#(
    parameter int COEFF_WIDTH    = iir_pkg::COEFF_WIDTH,
    parameter int LOG_A0         = iir_pkg::LOG_A0,
    parameter int LOG_GAIN_UNITY = iir_pkg::LOG_GAIN_UNITY,
    parameter int LOG_DIV        = iir_pkg::LOG_DIV
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [2:0]             wr_addr,
    input  logic [COEFF_WIDTH-1:0] wr_data,
    input  logic                   commit_req,
    input  logic                   err_clr,
    output logic [COEFF_WIDTH-1:0] b0,
    output logic [COEFF_WIDTH-1:0] b1,
    output logic [COEFF_WIDTH-1:0] b2,
    output logic [COEFF_WIDTH-1:0] a1,
    output logic [COEFF_WIDTH-1:0] a2,
    output logic [COEFF_WIDTH-1:0] gain,
    output logic                   busy,
    output logic                   frame_sync,
    output logic                   commit_done,
    output logic                   commit_rej,
    output logic                   err_sticky
);
    typedef logic [NUM_COEFF-1:0][COEFF_WIDTH-1:0] bank_t;

    function automatic bank_t rst_bank();
        bank_t b;
        b            = '0;
        b[ADDR_B0]   = COEFF_WIDTH'(unity(LOG_A0));
        b[ADDR_GAIN] = COEFF_WIDTH'(unity(LOG_GAIN_UNITY));
        return b;
    endfunction

    localparam bank_t RST_BANK = rst_bank();

    ld_state_e          state_q, state_d;
    bank_t              shadow_q, shadow_d, active_q, active_d;
    logic               err_q, err_d, commit_done_q, commit_done_d;
    logic [LOG_DIV-1:0] frame_cnt_q;
    logic               addr_ok, err_set, check_pass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_cnt_q <= '0;
        else     frame_cnt_q <= frame_cnt_q + 1'b1;
    end

    assign frame_sync = &frame_cnt_q;

    // The verdict is taken from the next-state shadow so that the value held
    // during CHECK already reflects a write made in the commit_req cycle.
`ifdef IIR_STAB_CHECK_EN
    iir_stab_check #(
        .COEFF_WIDTH(COEFF_WIDTH),
        .LOG_A0     (LOG_A0)
    ) u_stab (
        .clk   (clk),
        .rst   (rst),
        .a1_i  (shadow_d[ADDR_A1]),
        .a2_i  (shadow_d[ADDR_A2]),
        .pass_o(check_pass)
    );
`else
    assign check_pass = 1'b1;
`endif

    assign addr_ok = int'(wr_addr) < NUM_COEFF;

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        commit_done_d = 1'b0;
        commit_rej    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_en && addr_ok) shadow_d[wr_addr] = wr_data;
                if (commit_req)       state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (check_pass) begin
                    state_d = ST_ARMED;
                end else begin
                    commit_rej = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (frame_sync) begin
                    active_d      = shadow_q;
                    commit_done_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_set = commit_rej || (wr_en && (!addr_ok || state_q != ST_IDLE));
        err_d   = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shadow_q      <= RST_BANK;
            active_q      <= RST_BANK;
            err_q         <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            err_q         <= err_d;
            commit_done_q <= commit_done_d;
        end
    end

    assign b0          = active_q[ADDR_B0];
    assign b1          = active_q[ADDR_B1];
    assign b2          = active_q[ADDR_B2];
    assign a1          = active_q[ADDR_A1];
    assign a2          = active_q[ADDR_A2];
    assign gain        = active_q[ADDR_GAIN];
    assign busy        = (state_q != ST_IDLE);
    assign commit_done = commit_done_q;
    assign err_sticky  = err_q;

endmodule
